// File: rtl/rv_inst_encoder_if.sv
// Descriptor stream in, IROM write port out, for the RV32I instruction encoder.
// slave is the encoder's view; master is the view of the surrounding
// environment, which supplies descriptors and sinks IROM writes.
interface rv_inst_encoder_if #(
    parameter int unsigned ADDR_W = 14
);
    // Descriptor stream
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_fun3;
    logic              in_alt;
    logic [31:0]       in_imm;
    logic              in_last;
    // IROM write port
    logic              irom_we;
    logic              irom_ready;
    logic [ADDR_W-1:0] irom_addr;
    logic [31:0]       irom_wdata;

    modport slave (
        input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_fun3, in_alt, in_imm, in_last,
        output in_ready,
        output irom_we, irom_addr, irom_wdata,
        input  irom_ready
    );

    modport master (
        output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_fun3, in_alt, in_imm, in_last,
        input  in_ready,
        input  irom_we, irom_addr, irom_wdata,
        output irom_ready
    );
endinterface

// File: rtl/rv_inst_encoder.sv
// Streaming RV32I instruction encoder: packs descriptors into instruction words
// and writes them to consecutive IROM addresses through one output register.
module rv_inst_encoder #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    rv_inst_encoder_if.slave  bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BaseAddr = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] AddrOne  = 1;
    localparam logic [ADDR_W:0]   CountOne = 1;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [1:0] ErrImm  = 2'd1;
    localparam logic [1:0] ErrFun3 = 2'd2;
    localparam logic [1:0] ErrWrap = 2'd3;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              last_taken_q, last_taken_d;

    logic              in_ready_int;
    logic              start_ok;
    logic              accept;
    logic              complete;
    logic              drain;
    logic [31:0]       enc_word;
    logic [1:0]        enc_code;

    logic signed [31:0] imm_s;
    logic               fits_i;
    logic               fits_b;
    logic               fits_j;
    logic               is_shift;

    assign imm_s    = bus.in_imm;
    assign fits_i   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign fits_b   = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_s[0];
    assign fits_j   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm_s[0];
    assign is_shift = (bus.in_fun3 == 3'b001) || (bus.in_fun3 == 3'b101);

    assign start_ok = start && (state_q != StRun);
    assign accept   = bus.in_valid && in_ready_int;
    assign complete = we_q && bus.irom_ready;
    // The last descriptor has been taken and the output register empties this cycle.
    assign drain    = last_taken_q && (!we_q || bus.irom_ready);

    // Descriptor to instruction word, plus the legality verdict for it.
    always_comb begin
        enc_word = '0;
        enc_code = 2'd0;
        case (bus.in_fmt)
            3'd0: enc_word = {bus.in_alt ? 7'b0100000 : 7'b0000000, bus.in_rs2, bus.in_rs1,
                              bus.in_fun3, bus.in_rd, OpR};
            3'd1: begin
                if (is_shift) begin
                    enc_word = {1'b0, bus.in_alt, 5'b00000, bus.in_imm[4:0], bus.in_rs1,
                                bus.in_fun3, bus.in_rd, OpImm};
                    if (|bus.in_imm[31:5]) enc_code = ErrImm;
                end else begin
                    enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_fun3, bus.in_rd, OpImm};
                    if (!fits_i) enc_code = ErrImm;
                end
            end
            3'd2: begin
                enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, OpLoad};
                if (!fits_i) enc_code = ErrImm;
            end
            3'd3: begin
                enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OpJalr};
                if (!fits_i) enc_code = ErrImm;
            end
            3'd4: begin
                enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, bus.in_imm[4:0],
                            OpStore};
                if (!fits_i) enc_code = ErrImm;
            end
            3'd5: begin
                enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                            bus.in_fun3, bus.in_imm[4:1], bus.in_imm[11], OpBranch};
                // An unencodable condition outranks a bad offset.
                if (bus.in_fun3 == 3'b010 || bus.in_fun3 == 3'b011) enc_code = ErrFun3;
                else if (!fits_b)                                    enc_code = ErrImm;
            end
            3'd6: begin
                enc_word = {bus.in_imm[31:12], bus.in_rd, OpLui};
                if (|bus.in_imm[11:0]) enc_code = ErrImm;
            end
            3'd7: begin
                enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                            bus.in_rd, OpJal};
                if (!fits_j) enc_code = ErrImm;
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (drain) state_d = StDone;
            StDone:  if (start) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy         = (state_q == StRun);
        done         = (state_q == StDone);
        in_ready_int = (state_q == StRun) && (!we_q || bus.irom_ready) && !last_taken_q;
    end

    // Output register, address/count and error bookkeeping.
    always_comb begin
        logic err_seen;
        we_d         = we_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        count_d      = count_q;
        err_d        = err_q;
        code_d       = code_q;
        last_taken_d = last_taken_q;
        err_seen     = err_q;
        if (start_ok) begin
            addr_d       = BaseAddr;
            count_d      = '0;
            err_d        = 1'b0;
            code_d       = 2'd0;
            last_taken_d = 1'b0;
        end else begin
            if (complete) begin
                we_d    = 1'b0;
                addr_d  = addr_q + AddrOne;
                count_d = count_q + CountOne;
                // The wrapping write belongs to an older descriptor, so it is recorded first.
                if (addr_q == '1) begin
                    err_d = 1'b1;
                    if (!err_seen) code_d = ErrWrap;
                    err_seen = 1'b1;
                end
            end
            if (accept) begin
                if (bus.in_last) last_taken_d = 1'b1;
                if (enc_code != 2'd0) begin
                    err_d = 1'b1;
                    if (!err_seen) code_d = enc_code;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = enc_word;
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            wdata_q      <= '0;
            addr_q       <= BaseAddr;
            count_q      <= '0;
            err_q        <= 1'b0;
            code_q       <= 2'd0;
            last_taken_q <= 1'b0;
        end else begin
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            code_q       <= code_d;
            last_taken_q <= last_taken_d;
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.irom_we    = we_q;
    assign bus.irom_addr  = addr_q;
    assign bus.irom_wdata = wdata_q;
    assign err            = err_q;
    assign err_code       = code_q;
    assign count          = count_q;

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Bench for rv_inst_encoder: directed scenarios plus randomized streams scored
// against a queue-based reference model that encodes from the ISA field layout.
module tb_rv_inst_encoder;

    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    rv_inst_encoder_if #(.ADDR_W(AW)) bus ();

    rv_inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit rnd_rdy  = 0;
    bit mon_en   = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    int m_st;     // 0 idle, 1 run, 2 done
    int m_addr;
    int m_count;
    bit m_err;
    int m_code;
    bit m_last;

    int imm_tab [0:17] = '{0, -1, 8, 31, 32, 2047, 2048, -2048, -2049, 4094, 4095, 4096,
                           -4096, 1048574, 1048576, -1048576, 32'h12345000, 32'h12345001};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Instruction word built from the RV32I field layout with plain shifts and masks.
    function automatic void ref_enc(input int fmt, input int rd, input int rs1, input int rs2,
                                    input int f3, input int alt, input int imm,
                                    output logic [31:0] w, output int code);
        logic [31:0] u;
        logic [31:0] hi7;
        u    = imm;
        hi7  = (alt != 0) ? 32'h4000_0000 : 32'h0;
        code = 0;
        w    = 32'h0;
        case (fmt)
            0: w = hi7 | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7)
                   | 32'h33;
            1: begin
                if (f3 == 1 || f3 == 5) begin
                    if (imm < 0 || imm > 31) code = 1;
                    w = hi7 | ((u & 32'h1f) << 20);
                end else begin
                    if (imm < -2048 || imm > 2047) code = 1;
                    w = (u & 32'hfff) << 20;
                end
                w = w | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
            end
            2, 3: begin
                if (imm < -2048 || imm > 2047) code = 1;
                w = ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(rd) << 7)
                    | ((fmt == 2) ? 32'h2003 : 32'h67);
            end
            4: begin
                if (imm < -2048 || imm > 2047) code = 1;
                w = (((u >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                    | 32'h2000 | ((u & 32'h1f) << 7) | 32'h23;
            end
            5: begin
                if (f3 == 2 || f3 == 3) code = 2;
                else if (imm < -4096 || imm > 4094 || (imm % 2) != 0) code = 1;
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (32'(rs2) << 20)
                    | (32'(rs1) << 15) | (32'(f3) << 12) | (((u >> 1) & 32'hf) << 8)
                    | (((u >> 11) & 1) << 7) | 32'h63;
            end
            6: begin
                if ((u & 32'hfff) != 0) code = 1;
                w = (u & 32'hffff_f000) | (32'(rd) << 7) | 32'h37;
            end
            default: begin
                if (imm < -1048576 || imm > 1048574 || (imm % 2) != 0) code = 1;
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21)
                    | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) | (32'(rd) << 7)
                    | 32'h6f;
            end
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_st = 0; m_addr = 0; m_count = 0; m_err = 0; m_code = 0; m_last = 0;
    endtask

    // Scoreboard: compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin : mon
        logic [31:0] w;
        int  code;
        bit  exp_rdy, wr, acc, drain;
        if (mon_en) begin
            exp_rdy = (m_st == 1) && !m_last && (exp_q.size() == 0 || bus.irom_ready);
            check_eq("busy", busy, m_st == 1);
            check_eq("done", done, m_st == 2);
            check_eq("err", err, m_err);
            check_eq("err_code", err_code, m_code);
            check_eq("count", count, m_count);
            check_eq("addr", bus.irom_addr, m_addr);
            check_eq("irom_we", bus.irom_we, exp_q.size() != 0);
            check_eq("in_ready", bus.in_ready, exp_rdy);
            if (exp_q.size() != 0) check_eq("wdata", bus.irom_wdata, exp_q[0]);

            wr  = (exp_q.size() != 0) && bus.irom_ready;
            acc = bus.in_valid && exp_rdy;
            if (start && m_st != 1) begin
                m_st = 1; m_addr = 0; m_count = 0; m_err = 0; m_code = 0; m_last = 0;
            end else if (m_st == 1) begin
                drain = m_last && (exp_q.size() == 0 || wr);
                if (wr) begin
                    void'(exp_q.pop_front());
                    if (m_addr == (1 << AW) - 1) begin
                        if (!m_err) m_code = 3;
                        m_err = 1;
                    end
                    m_addr  = (m_addr + 1) % (1 << AW);
                    m_count = (m_count + 1) % (2 << AW);
                end
                if (acc) begin
                    ref_enc(int'(bus.in_fmt), int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2),
                            int'(bus.in_fun3), int'(bus.in_alt), int'($signed(bus.in_imm)),
                            w, code);
                    if (code != 0) begin
                        if (!m_err) m_code = code;
                        m_err = 1;
                    end else begin
                        exp_q.push_back(w);
                    end
                    if (bus.in_last) m_last = 1;
                end
                if (drain) m_st = 2;
            end
        end
    end

    // Advance to just after the next rising edge; all input changes happen here.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rnd_rdy) bus.irom_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic set_desc(input int fmt, input int rd, input int rs1, input int rs2,
                            input int f3, input int alt, input int imm, input int last);
        bus.in_fmt  = 3'(fmt);
        bus.in_rd   = 5'(rd);
        bus.in_rs1  = 5'(rs1);
        bus.in_rs2  = 5'(rs2);
        bus.in_fun3 = 3'(f3);
        bus.in_alt  = 1'(alt);
        bus.in_imm  = imm;
        bus.in_last = 1'(last);
    endtask

    // Present the current descriptor until accepted; returns just after the accepting edge.
    task automatic send();
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_valid && bus.in_ready;
            tick();
        end
        if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (done) ok = 1;
            else tick();
        end
        if (!ok) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic rand_desc(input int last);
        int fmt, imm;
        fmt = $urandom_range(0, 7);
        case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = $urandom_range(0, 4000) * 2 - 4000;
            default: imm = imm_tab[$urandom_range(0, 17)];
        endcase
        set_desc(fmt, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 7), $urandom_range(0, 1), imm, last);
    endtask

    initial begin
        int c0;
        model_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.irom_ready = 1'b1;
        set_desc(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check_eq("rst_we", bus.irom_we, 0);
        check_eq("rst_addr", bus.irom_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        #9 rst_n = 1'b1;
        tick();
        mon_en = 1;

        // Basic encodings, illegal immediate, wrap after an earlier error, completion.
        do_start();
        set_desc(0, 3, 1, 2, 0, 0, 0, 0); send();
        check_eq("r_add_we", bus.irom_we, 1);
        check_eq("r_add_addr", bus.irom_addr, 0);
        check_eq("r_add_word", bus.irom_wdata, 32'h002081B3);
        set_desc(0, 3, 1, 2, 0, 1, 0, 0); send();
        check_eq("r_sub_addr", bus.irom_addr, 1);
        check_eq("r_sub_word", bus.irom_wdata, 32'h402081B3);
        bus.in_valid = 1'b0;
        tick();
        check_eq("count_two", count, 2);
        set_desc(1, 5, 0, 0, 0, 0, -1, 0); send();
        check_eq("addi_word", bus.irom_wdata, 32'hFFF00293);
        check_eq("addi_addr", bus.irom_addr, 2);
        set_desc(1, 5, 0, 0, 0, 0, 2048, 0); send();
        check_eq("bad_imm_err", err, 1);
        check_eq("bad_imm_code", err_code, 1);
        check_eq("bad_imm_we", bus.irom_we, 0);
        check_eq("bad_imm_addr", bus.irom_addr, 3);
        set_desc(5, 0, 1, 2, 0, 0, 8, 0); send();
        check_eq("beq_word", bus.irom_wdata, 32'h00208463);
        set_desc(6, 1, 0, 0, 0, 0, 32'h12345000, 0); send();
        check_eq("lui_word", bus.irom_wdata, 32'h123450B7);
        check_eq("lui_addr_wrapped", bus.irom_addr, 0);
        set_desc(7, 1, 0, 0, 0, 0, 2048, 1); send();
        check_eq("jal_word", bus.irom_wdata, 32'h001000EF);
        bus.in_valid = 1'b0;
        wait_done();
        check_eq("first_code_kept", err_code, 1);
        check_eq("end_busy", busy, 0);
        check_eq("end_count", count, 6);

        // Address wrap on a clean stream.
        do_start();
        for (int k = 1; k <= 5; k++) begin
            set_desc(0, k, 1, 2, 0, 0, 0, (k == 5) ? 1 : 0);
            send();
            if (k == 4) check_eq("pre_wrap_code", err_code, 0);
        end
        bus.in_valid = 1'b0;
        check_eq("wrap_code", err_code, 3);
        check_eq("wrap_addr", bus.irom_addr, 0);
        wait_done();
        check_eq("wrap_count", count, 5);

        // Backpressure: one word held, then full-rate drain.
        do_start();
        bus.irom_ready = 1'b0;
        set_desc(0, 1, 0, 0, 0, 0, 0, 0); send();
        set_desc(0, 2, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("hold_we", bus.irom_we, 1);
            check_eq("hold_ready", bus.in_ready, 0);
            check_eq("hold_addr", bus.irom_addr, 0);
            check_eq("hold_word", bus.irom_wdata, 32'h000000B3);
            tick();
        end
        bus.irom_ready = 1'b1;
        send();
        c0 = cyc;
        set_desc(0, 3, 0, 0, 0, 0, 0, 0); send();
        set_desc(0, 4, 0, 0, 0, 0, 0, 1); send();
        bus.in_valid = 1'b0;
        check_eq("b2b_cycles", cyc - c0, 2);
        check_eq("b2b_addr", bus.irom_addr, 3);
        wait_done();

        // Randomized streams with random IROM backpressure.
        rnd_rdy = 1;
        for (int s = 0; s < 25; s++) begin
            int len;
            len = $urandom_range(1, 9);
            do_start();
            for (int k = 0; k < len; k++) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                rand_desc((k == len - 1) ? 1 : 0);
                send();
            end
            bus.in_valid = 1'b0;
            wait_done();
        end
        rnd_rdy = 0;
        bus.irom_ready = 1'b1;

        // Asynchronous reset with a word in flight.
        do_start();
        bus.irom_ready = 1'b0;
        set_desc(0, 7, 1, 1, 0, 0, 0, 0); send();
        bus.in_valid = 1'b0;
        mon_en = 0;
        check_eq("pre_rst_we", bus.irom_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_we", bus.irom_we, 0);
        check_eq("arst_addr", bus.irom_addr, 0);
        check_eq("arst_wdata", bus.irom_wdata, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_count", count, 0);
        tick();
        rst_n = 1'b1;
        bus.irom_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("post_rst_ready", bus.in_ready, 0);
            check_eq("post_rst_we", bus.irom_we, 0);
        end
        bus.in_valid = 1'b0;
        model_reset();
        mon_en = 1;
        do_start();
        set_desc(4, 0, 2, 3, 0, 0, -4, 1); send();
        bus.in_valid = 1'b0;
        check_eq("sw_word", bus.irom_wdata, 32'hFE312E23);
        wait_done();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
Streaming RV32I instruction encoder. It is the inverse of the single-cycle control decoder: it takes structured instruction descriptors (format, registers, fun3, alt bit, immediate), packs them into 32-bit instruction words, and writes them sequentially into IROM through a ready-handshaked write port. It is used by the program loader and self-test logic to build instruction streams in hardware.

Parameters:
ADDR_W, 14, IROM word-address width.
BASE_ADDR, 0, first word address written after start.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  pulse; arms the encoder, honoured only in IDLE or DONE.
in_valid  in  1  descriptor valid.
in_ready  out  1  descriptor accepted when in_valid&in_ready.
in_fmt  in  3  0 R, 1 I-ALU, 2 LOAD(lw), 3 JALR, 4 S(sw), 5 B, 6 U(lui), 7 J(jal).
in_rd / in_rs1 / in_rs2  in  5 each  register fields.
in_fun3  in  3  used for R, I-ALU and B only.
in_alt  in  1  fun7[5] (sub/sra/srai).
in_imm  in  32  signed byte-offset or value immediate.
in_last  in  1  final descriptor of the stream.
irom_we  out  1  write strobe; this is also the write-valid signal.
irom_ready  in  1  IROM accepts the write when irom_we&irom_ready.
irom_addr  out  ADDR_W  word address.
irom_wdata  out  32  encoded instruction.
busy  out  1  high in RUN.
done  out  1  high in DONE.
err  out  1  sticky error flag.
err_code  out  2  first error: 1 immediate range/alignment, 2 illegal fun3, 3 address wrap.
count  out  ADDR_W+1  number of words written.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. irom_addr=BASE_ADDR.
- FSM:
  - IDLE -start-> RUN. Asserting start clears err, err_code and count, and loads irom_addr=BASE_ADDR.
  - RUN: after the in_last descriptor is accepted and its write completes (or it is dropped), go to DONE.
  - DONE -start-> RUN.
  - start in RUN is ignored.
- Pipeline: one output register stage.
  - in_ready = (state==RUN) & (!irom_we | irom_ready) & !last_taken.
  - last_taken is set when in_last is accepted and cleared on start.
  - An accepted, legal descriptor is encoded combinationally and registered. irom_we rises on the next cycle, giving 1-cycle latency.
  - irom_we, irom_addr and irom_wdata hold stable while irom_ready=0.
  - On a completed write: irom_addr+1, count+1. A new word may load in the same cycle, so full throughput is 1 word per cycle.
- Encoding (opcode / fun3):
  - R: 0110011, fun3 from in_fun3, fun7 = in_alt ? 0100000 : 0.
  - I-ALU: 0010011, fun3 from in_fun3. For fun3 001/101, bits[31:25] = in_alt ? 0100000 : 0 and bits[24:20] = imm[4:0]. Otherwise bits[31:20] = imm[11:0].
  - LOAD: 0000011, fun3 forced to 010.
  - JALR: 1100111, fun3 000.
  - S: 0100011, fun3 010, imm[11:5] -> bits[31:25], imm[4:0] -> bits[11:7].
  - B: 1100011, standard imm[12|10:5], imm[4:1|11] split.
  - U: 0110111, bits[31:12] = imm[31:12].
  - J: 1101111, standard imm[20|10:1|11|19:12] split.
  - Unused rd/rs fields are 0.
- Checks (all treat in_imm as signed 32-bit):
  - I-ALU, LOAD, JALR, S: imm must be in [-2048, 2047].
  - Shifts: imm[31:5] must be 0.
  - B: imm in [-4096, 4094] and even.
  - J: imm in [-2^20, 2^20-2] and even.
  - U: imm[11:0] must be 0.
  - B with fun3 010 or 011 raises code 2.
- Error handling:
  - An illegal descriptor is still accepted but not written. Address and count are unchanged.
  - err is set sticky; err_code latches only the first error.
  - If the illegal descriptor carries in_last, go to DONE once the pipe drains.
- Address wrap: a completed write at irom_addr = 2^ADDR_W-1 wraps the address to 0 and raises code 3. The stream continues.
- Reset mid-stream: async abort. Any in-flight word is lost and everything returns to reset values.

Test Plan:
- start, then R add rd=3 rs1=1 rs2=2 fun3=0 alt=0 -> next cycle irom_we=1, addr 0, wdata 0x002081B3. Same with alt=1 -> 0x402081B3 at addr 1. count=2.
- I-ALU rd=5 rs1=0 imm=-1 -> 0xFFF00293. I-ALU imm=2048 -> no write, err=1, err_code=1, addr unchanged.
- B fun3=0 rs1=1 rs2=2 imm=8 -> 0x00208463. U rd=1 imm=0x12345000 -> 0x123450B7. J rd=1 imm=2048, in_last=1 -> 0x001000EF, then done=1, busy=0.
- Hold irom_ready=0 for 3 cycles with in_valid=1 -> one word held stable, in_ready=0, addr frozen. On release, back-to-back writes at 1 word per cycle with consecutive addresses.
- ADDR_W=2, 5 legal words -> addresses 0,1,2,3,0, err_code=3 after the 4th write, count=5.
- rst_n low while irom_we=1 -> all outputs 0 immediately. in_valid ignored until start.
